cp0_regfile_v2: RTL
===================

Name: cp0_regfile_v2

Overview:
- Parametrised second-generation CP0 for the MIPS core. Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Prioritises interrupts over synchronous exceptions and handles ERET.
- Drives a registered pipeline flush and redirect target.
- Adds over the first generation: configurable hardware-interrupt count, configurable exception vector, Count prescaler, Cause.TI, Status.IE gating, and correct EXL-nested behaviour.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6); mapped to Cause.IP[2+k].
- EXC_VECTOR, 32'hBFC0_0380, redirect target for all exceptions and interrupts.
- STATUS_RESET, 32'h0040_0000, Status value on reset (BEV=1).
- COUNT_DIV, 2, core cycles per Count increment (>=1).

Ports:
- clock_i  in  1  core clock
- reset_i  in  1  asynchronous, active-high reset
- cp0_read_addr_i  in  5  MFC0 register number
- cp0_read_data_o  out  32  MFC0 data, combinational
- cp0_write_enable_i  in  1  MTC0 commit
- cp0_write_addr_i  in  5  MTC0 register number
- cp0_write_data_i  in  32  MTC0 data
- commit_valid_i  in  1  an instruction is at the commit point this cycle
- commit_pc_i  in  32  PC of the committing instruction
- commit_delayslot_i  in  1  committing instruction is in a delay slot
- exc_valid_i  in  1  synchronous exception on the committing instruction
- exc_code_i  in  5  ExcCode, already prioritised upstream
- exc_badvaddr_i  in  32  faulting address (used for AdEL/AdES only)
- eret_i  in  1  committing instruction is ERET
- int_i  in  NUM_HW_INT  level-sensitive hardware interrupts
- flush_o  out  1  one-cycle pipeline flush
- redirect_pc_o  out  32  fetch target, valid while flush_o=1
- timer_int_o  out  1  mirrors Cause.TI
- status_o  out  32  current Status, for the decoder

Behaviour:
- Reset (async): Status=STATUS_RESET; all other registers 0; divider phase 0; flush_o=0, redirect_pc_o=0, timer_int_o=0.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - Count, Compare, EPC: all bits.
  - BadVAddr: read-only.
  - Unlisted addresses read 0.
- Read bypass: if write_enable and read_addr==write_addr, return the stored value with writable bits replaced by write data.
- Cause.IP[2+k] = int_i[k], sampled every cycle. IP[7] |= TI. Unused IP bits = 0.
- Timer:
  - Count increments once every COUNT_DIV cycles; wraps FFFF_FFFF->0.
  - TI sets in the cycle Count's new value equals Compare (including 0).
  - TI clears on any Compare write.
  - An MTC0 to Count loads the value and resets the divider phase.
- int_req = IE & ~EXL & |(IP[15:8] & IM[15:8]).
- Event selection, evaluated only when commit_valid_i=1 and flush_o=0, in priority order:
  1. Interrupt, if int_req: ExcCode=0.
  2. Exception, if exc_valid_i: ExcCode=exc_code_i. BadVAddr=exc_badvaddr_i only if code is 4 or 5.
  3. ERET, if eret_i: EXL<=0, redirect_pc_o<=EPC.
- On interrupt or exception:
  - If EXL was 0: EPC = delayslot ? pc-4 : pc, and BD = delayslot.
  - If EXL was 1: EPC and BD are unchanged.
  - EXL<=1, redirect_pc_o<=EXC_VECTOR.
- Latency: registers update at the event edge. flush_o=1 in the following cycle for exactly one cycle, then returns to 0.
- While flush_o=1, all commit inputs are ignored, including MTC0.
- An MTC0 in the same cycle as a taken interrupt or exception is discarded (the instruction is killed).
- An MTC0 with ERET cannot occur; MTC0 takes precedence if asserted.
- Interrupts are level-sensitive: re-taken after ERET if still pending and unmasked.
- Reset asserted mid-flush forces flush_o=0 immediately.

Test Plan:
- Reset -> Status=0040_0000, Count=0, flush_o=0, redirect_pc_o=0, all reads of 8/9/11/13/14 return 0.
- COUNT_DIV=2; write Compare=5, Count=0 -> TI=1 and timer_int_o=1 after 10 cycles. With IE=1 and IM[7]=1, the next commit at pc=BFC0_1000 -> EPC=BFC0_1000, ExcCode=0, flush_o high for one cycle, redirect_pc_o=BFC0_0380.
- Exception code 4, badvaddr=0000_0003, pc=BFC0_2004, delayslot=1 -> EPC=BFC0_2000, BD=1, BadVAddr=3, EXL=1, flush_o pulse.
- Exception taken while EXL=1 -> EPC unchanged, ExcCode updated, flush_o pulse. Then ERET -> EXL=0, redirect_pc_o=EPC.
- int_i[2]=1 with IM[4]=1, IE=1 plus exc_valid_i (code 10) in the same cycle -> ExcCode=0 (interrupt wins). The simultaneous MTC0 to Compare is discarded.
- MTC0 Status=FFFF_FFFF with same-cycle MFC0 Status -> read 0040_FF03; the stored value equals it the next cycle.

Source files
------------

// File: rtl/cp0_regfile_v2_if.sv
// Bus bundle between the commit stage and the second-generation CP0 register file.
// Signal names match the core's existing CP0 port list so the wiring can be traced directly.
interface cp0_regfile_v2_if #(
  parameter int unsigned NUM_HW_INT = 6
);
  logic [4:0]            cp0_read_addr_i;
  logic [31:0]           cp0_read_data_o;
  logic                  cp0_write_enable_i;
  logic [4:0]            cp0_write_addr_i;
  logic [31:0]           cp0_write_data_i;
  logic                  commit_valid_i;
  logic [31:0]           commit_pc_i;
  logic                  commit_delayslot_i;
  logic                  exc_valid_i;
  logic [4:0]            exc_code_i;
  logic [31:0]           exc_badvaddr_i;
  logic                  eret_i;
  logic [NUM_HW_INT-1:0] int_i;
  logic                  flush_o;
  logic [31:0]           redirect_pc_o;
  logic                  timer_int_o;
  logic [31:0]           status_o;

  modport master (
    output cp0_read_addr_i, cp0_write_enable_i, cp0_write_addr_i, cp0_write_data_i,
    output commit_valid_i, commit_pc_i, commit_delayslot_i,
    output exc_valid_i, exc_code_i, exc_badvaddr_i, eret_i, int_i,
    input  cp0_read_data_o, flush_o, redirect_pc_o, timer_int_o, status_o
  );

  modport slave (
    input  cp0_read_addr_i, cp0_write_enable_i, cp0_write_addr_i, cp0_write_data_i,
    input  commit_valid_i, commit_pc_i, commit_delayslot_i,
    input  exc_valid_i, exc_code_i, exc_badvaddr_i, eret_i, int_i,
    output cp0_read_data_o, flush_o, redirect_pc_o, timer_int_o, status_o
  );
endinterface

// File: rtl/cp0_regfile_v2.sv
// Second-generation CP0: BadVAddr/Count/Compare/Status/Cause/EPC, interrupt and exception
// entry, ERET, and a registered one-cycle flush with redirect target.
module cp0_regfile_v2 #(
  parameter int unsigned NUM_HW_INT   = 6,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
  parameter int unsigned COUNT_DIV    = 2
) (
  input logic             clock_i,
  input logic             reset_i,
  cp0_regfile_v2_if.slave bus
);

  localparam logic [4:0]  AddrBadVAddr = 5'd8;
  localparam logic [4:0]  AddrCount    = 5'd9;
  localparam logic [4:0]  AddrCompare  = 5'd11;
  localparam logic [4:0]  AddrStatus   = 5'd12;
  localparam logic [4:0]  AddrCause    = 5'd13;
  localparam logic [4:0]  AddrEpc      = 5'd14;
  localparam logic [31:0] StatusWmask  = 32'h0000_FF03;
  localparam logic [31:0] CauseWmask   = 32'h0000_0300;
  localparam int unsigned DivW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           status_q, status_d;
  logic [31:0]           epc_q, epc_d;
  logic                  bd_q, bd_d;
  logic                  ti_q, ti_d;
  logic [4:0]            exc_code_q, exc_code_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [NUM_HW_INT-1:0] ip_hw_q;
  logic [DivW-1:0]       div_q, div_d;
  logic                  flush_q, flush_d;
  logic [31:0]           redirect_q, redirect_d;

  logic [7:0]  ip;
  logic [31:0] cause_val;
  logic [31:0] count_inc;
  logic        tick;
  logic        int_req, event_ok, take_int, take_exc, take_trap, take_eret, wr_en;
  logic [31:0] rd_stored, rd_wmask;

  // Cause.IP[15:8]: two software bits, hardware lines from IP[10] up, timer folded into IP[7].
  always_comb begin
    ip = {6'b0, ip_sw_q};
    for (int k = 0; k < NUM_HW_INT; k++) begin
      ip[2+k] = ip_hw_q[k];
    end
    ip[7] = ip[7] | ti_q;
  end

  assign cause_val = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b00};
  assign int_req   = status_q[0] & ~status_q[1] & (|(ip & status_q[15:8]));

  // Commit inputs are dead while the flush from the previous event is in flight.
  assign event_ok  = bus.commit_valid_i & ~flush_q;
  assign take_int  = event_ok & int_req;
  assign take_exc  = event_ok & ~int_req & bus.exc_valid_i;
  assign take_trap = take_int | take_exc;
  assign take_eret = event_ok & ~int_req & ~bus.exc_valid_i & bus.eret_i &
                     ~bus.cp0_write_enable_i;
  assign wr_en     = bus.cp0_write_enable_i & ~flush_q & ~take_trap;

  assign tick      = (div_q == DivW'(COUNT_DIV - 1));
  assign count_inc = count_q + 32'd1;

  always_comb begin
    rd_stored = 32'h0;
    rd_wmask  = 32'h0;
    case (bus.cp0_read_addr_i)
      AddrBadVAddr: rd_stored = badvaddr_q;
      AddrCount:    begin rd_stored = count_q;   rd_wmask = 32'hFFFF_FFFF; end
      AddrCompare:  begin rd_stored = compare_q; rd_wmask = 32'hFFFF_FFFF; end
      AddrStatus:   begin rd_stored = status_q;  rd_wmask = StatusWmask;   end
      AddrCause:    begin rd_stored = cause_val; rd_wmask = CauseWmask;    end
      AddrEpc:      begin rd_stored = epc_q;     rd_wmask = 32'hFFFF_FFFF; end
      default:      ;
    endcase
    if (bus.cp0_write_enable_i && (bus.cp0_read_addr_i == bus.cp0_write_addr_i)) begin
      bus.cp0_read_data_o = (rd_stored & ~rd_wmask) | (bus.cp0_write_data_i & rd_wmask);
    end else begin
      bus.cp0_read_data_o = rd_stored;
    end
  end

  always_comb begin
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    redirect_d = redirect_q;
    div_d      = tick ? '0 : div_q + DivW'(1);
    count_d    = tick ? count_inc : count_q;
    ti_d       = ti_q | (tick & (count_inc == compare_q));

    if (wr_en) begin
      case (bus.cp0_write_addr_i)
        AddrCount: begin
          count_d = bus.cp0_write_data_i;
          div_d   = '0;
          ti_d    = ti_q;
        end
        AddrCompare: begin
          compare_d = bus.cp0_write_data_i;
          ti_d      = 1'b0;
        end
        AddrStatus: status_d = (status_q & ~StatusWmask) | (bus.cp0_write_data_i & StatusWmask);
        AddrCause:  ip_sw_d  = bus.cp0_write_data_i[9:8];
        AddrEpc:    epc_d    = bus.cp0_write_data_i;
        default:    ;
      endcase
    end

    if (take_trap) begin
      // A nested trap keeps the original return point.
      if (!status_q[1]) begin
        epc_d = bus.commit_delayslot_i ? bus.commit_pc_i - 32'd4 : bus.commit_pc_i;
        bd_d  = bus.commit_delayslot_i;
      end
      exc_code_d = take_int ? 5'd0 : bus.exc_code_i;
      if (take_exc && (bus.exc_code_i == 5'd4 || bus.exc_code_i == 5'd5)) begin
        badvaddr_d = bus.exc_badvaddr_i;
      end
      status_d[1] = 1'b1;
      redirect_d  = EXC_VECTOR;
    end else if (take_eret) begin
      status_d[1] = 1'b0;
      redirect_d  = epc_q;
    end

    flush_d = take_trap | take_eret;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= STATUS_RESET;
      epc_q      <= '0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      div_q      <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= bus.int_i;
      div_q      <= div_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.flush_o       = flush_q;
  assign bus.redirect_pc_o = redirect_q;
  assign bus.timer_int_o   = ti_q;
  assign bus.status_o      = status_q;

endmodule
